// File: rtl/song_sequencer_if.sv
// Note-load handshake plus song ROM port shared by song_sequencer (master),
// note_player and the song ROM (slave side).
interface song_sequencer_if #(
    parameter int unsigned NOTE_ADDR_W = 5
) ();
    localparam int unsigned ADDR_W = 2 + NOTE_ADDR_W;

    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [5:0]        note_to_load;
    logic [5:0]        duration_to_load;
    logic [1:0]        stereo_side_to_load;
    logic              load_new_note;
    logic              done_with_note;

    modport master (
        output rom_addr,
        output note_to_load,
        output duration_to_load,
        output stereo_side_to_load,
        output load_new_note,
        input  rom_data,
        input  done_with_note
    );

    modport slave (
        input  rom_addr,
        input  note_to_load,
        input  duration_to_load,
        input  stereo_side_to_load,
        input  load_new_note,
        output rom_data,
        output done_with_note
    );
endinterface

// File: rtl/song_sequencer.sv
// Walks the selected song in ROM and hands one note at a time to note_player,
// waiting for its done pulse between notes.
module song_sequencer #(
    parameter int unsigned NOTE_ADDR_W = 5,
    parameter int unsigned ROM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             play,
    input  logic [1:0]       song,
    output logic             song_done,
    song_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        WAIT_DONE,
        FINISHED
    } state_e;

    state_e                 state_q, state_d;
    logic [NOTE_ADDR_W-1:0] index_q, index_d;
    logic [1:0]             song_q, song_d;
    logic [5:0]             note_q, note_d;
    logic [5:0]             dur_q, dur_d;
    logic [1:0]             side_q, side_d;
    logic                   load_q, load_d;
    logic                   done_q, done_d;
    logic                   song_change;

    // Reserved ROM bit and the fixed one-cycle ROM latency carry no logic.
    logic unused_bits;
    assign unused_bits = ^{bus.rom_data[14], 1'(ROM_LATENCY)};

    assign bus.rom_addr            = {song_q, index_q};
    assign bus.note_to_load        = note_q;
    assign bus.duration_to_load    = dur_q;
    assign bus.stereo_side_to_load = side_q;
    assign bus.load_new_note       = load_q;
    assign song_done               = done_q;

    assign song_change = (state_q != IDLE) && (song != song_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            index_q <= '0;
            song_q  <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            side_q  <= '0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            song_q  <= song_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            side_q  <= side_d;
            load_q  <= load_d;
            done_q  <= done_d;
        end
    end

    // A song change restarts the walk from entry 0 and wins over done_with_note.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        song_d  = song_q;
        note_d  = note_q;
        dur_d   = dur_q;
        side_d  = side_q;
        load_d  = 1'b0;
        done_d  = done_q;

        if (song_change) begin
            state_d = FETCH;
            index_d = '0;
            song_d  = song;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    song_d = song;
                    if (play) begin
                        state_d = FETCH;
                        index_d = '0;
                    end
                end
                FETCH: begin
                    if (play) state_d = DECODE;
                end
                DECODE: begin
                    if (bus.rom_data[15]) begin
                        state_d = FINISHED;
                        done_d  = 1'b1;
                    end else begin
                        note_d  = bus.rom_data[11:6];
                        dur_d   = bus.rom_data[5:0];
                        side_d  = bus.rom_data[13:12];
                        load_d  = 1'b1;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.done_with_note) begin
                        if (index_q == '1) begin
                            state_d = FINISHED;
                            done_d  = 1'b1;
                        end else begin
                            index_d = index_q + NOTE_ADDR_W'(1);
                            state_d = FETCH;
                        end
                    end
                end
                FINISHED: begin
                    state_d = FINISHED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: directed vector table, hand-written
// corner sequences and randomized songs against a transaction-level model.
module tb_song_sequencer;
    localparam int unsigned AW      = 2;
    localparam int unsigned ENTRIES = 1 << AW;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [1:0] song;
    logic       song_done;

    int checks     = 0;
    int failures   = 0;
    int load_count = 0;

    logic [15:0] rom_mem [16];

    song_sequencer_if #(.NOTE_ADDR_W(AW)) sif ();

    song_sequencer #(.NOTE_ADDR_W(AW), .ROM_LATENCY(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .song_done (song_done),
        .bus       (sif)
    );

    always #5 clk = ~clk;

    // One-cycle-latency song ROM.
    always @(posedge clk) sif.rom_data <= rom_mem[sif.rom_addr];

    always @(negedge clk) if (sif.load_new_note === 1'b1) load_count++;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        int          skip;
        logic        play;
        logic        done;
        logic [1:0]  song;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [19:0] outs();
        return {sif.load_new_note, sif.note_to_load, sif.duration_to_load,
                sif.stereo_side_to_load, song_done, sif.rom_addr};
    endfunction

    function automatic logic [19:0] pack(input logic ld, input logic [5:0] n, input logic [5:0] d,
                                         input logic [1:0] sd, input logic sdn, input logic [3:0] a);
        return {ld, n, d, sd, sdn, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        play  = 1'b0;
        sif.done_with_note = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
    endtask

    task automatic wait_load(input int budget, output int waited, output bit got);
        got = 1'b0;
        waited = 0;
        while (!got && waited < budget) begin
            step();
            waited++;
            if (sif.load_new_note === 1'b1) got = 1'b1;
        end
    endtask

    task automatic wait_sdone(input int budget, output int waited);
        waited = 0;
        while (song_done !== 1'b1 && waited < budget) begin
            step();
            waited++;
        end
    endtask

    // Reference: a song is its entries up to the first end marker, at most ENTRIES long.
    function automatic int song_len(input logic [1:0] s);
        for (int i = 0; i < int'(ENTRIES); i++)
            if (rom_mem[4'(int'(s) * int'(ENTRIES) + i)][15]) return i;
        return int'(ENTRIES);
    endfunction

    task automatic run_song(input logic [1:0] s, input bit spurious);
        int n, w, lc0, exp_lat;
        bit got;
        logic [15:0] e;
        n   = song_len(s);
        lc0 = load_count;
        song = s;
        play = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_load(8, w, got);
            check("load_latency", 32'((i == 0) ? w : w + 1), 32'd3);
            e = rom_mem[4'(int'(s) * int'(ENTRIES) + i)];
            check("load_fields",
                  32'({got, sif.note_to_load, sif.duration_to_load, sif.stereo_side_to_load}),
                  32'({1'b1, e[11:6], e[5:0], e[13:12]}));
            sif.done_with_note = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            sif.done_with_note = 1'b0;
            repeat ($urandom_range(0, 6)) step();
            sif.done_with_note = 1'b1;
            step();
            sif.done_with_note = 1'b0;
        end
        wait_sdone(8, w);
        exp_lat = (n == 0 || n != int'(ENTRIES)) ? 3 : 1;
        check("song_done_latency", 32'((n == 0) ? w : w + 1), 32'(exp_lat));
        check("end_addr", 32'(sif.rom_addr),
              32'({s, AW'((n == int'(ENTRIES)) ? int'(ENTRIES) - 1 : n)}));
        repeat (5) begin
            sif.done_with_note = 1'b1;
            step();
            sif.done_with_note = 1'b0;
            step();
        end
        check("song_load_count", 32'(load_count - lc0), 32'(n));
        check("song_done_hold", 32'(song_done), 32'd1);
    endtask

    initial begin
        int  lc0, w;
        bit  got;

        rom_mem[0]  = 16'h1304;  // note 12, dur 4, side 01
        rom_mem[1]  = 16'h2502;  // note 20, dur 2, side 10
        rom_mem[2]  = 16'h8000;
        rom_mem[3]  = 16'h0000;
        rom_mem[4]  = 16'h21C0;  // note 7, dur 0, side 10
        rom_mem[5]  = 16'h8000;
        rom_mem[6]  = 16'h8000;
        rom_mem[7]  = 16'h8000;
        rom_mem[8]  = 16'h1FFF;  // note 63, dur 63, side 01
        rom_mem[9]  = 16'h8000;
        rom_mem[10] = 16'h8000;
        rom_mem[11] = 16'h8000;
        rom_mem[12] = 16'h1041;  // song 3 has no end marker
        rom_mem[13] = 16'h2082;
        rom_mem[14] = 16'h10C3;
        rom_mem[15] = 16'h2104;

        vecs[0]  = '{0,  1'b1, 1'b0, 2'd0, pack(1'b0, 6'd0,  6'd0, 2'b00, 1'b0, 4'd0)};
        vecs[1]  = '{0,  1'b1, 1'b0, 2'd0, pack(1'b0, 6'd0,  6'd0, 2'b00, 1'b0, 4'd0)};
        vecs[2]  = '{0,  1'b1, 1'b0, 2'd0, pack(1'b1, 6'd12, 6'd4, 2'b01, 1'b0, 4'd0)};
        vecs[3]  = '{0,  1'b1, 1'b0, 2'd0, pack(1'b0, 6'd12, 6'd4, 2'b01, 1'b0, 4'd0)};
        vecs[4]  = '{8,  1'b1, 1'b1, 2'd0, pack(1'b0, 6'd12, 6'd4, 2'b01, 1'b0, 4'd1)};
        vecs[5]  = '{0,  1'b1, 1'b0, 2'd0, pack(1'b0, 6'd12, 6'd4, 2'b01, 1'b0, 4'd1)};
        vecs[6]  = '{0,  1'b1, 1'b0, 2'd0, pack(1'b1, 6'd20, 6'd2, 2'b10, 1'b0, 4'd1)};
        vecs[7]  = '{0,  1'b1, 1'b0, 2'd0, pack(1'b0, 6'd20, 6'd2, 2'b10, 1'b0, 4'd1)};
        vecs[8]  = '{8,  1'b1, 1'b1, 2'd0, pack(1'b0, 6'd20, 6'd2, 2'b10, 1'b0, 4'd2)};
        vecs[9]  = '{0,  1'b1, 1'b0, 2'd0, pack(1'b0, 6'd20, 6'd2, 2'b10, 1'b0, 4'd2)};
        vecs[10] = '{0,  1'b1, 1'b0, 2'd0, pack(1'b0, 6'd20, 6'd2, 2'b10, 1'b1, 4'd2)};
        vecs[11] = '{20, 1'b1, 1'b1, 2'd0, pack(1'b0, 6'd20, 6'd2, 2'b10, 1'b1, 4'd2)};
        vecs[12] = '{0,  1'b0, 1'b0, 2'd1, pack(1'b0, 6'd20, 6'd2, 2'b10, 1'b0, 4'd4)};

        reset = 1'b1;
        play  = 1'b0;
        song  = 2'd0;
        sif.done_with_note = 1'b0;
        #2 reset = 1'b0;
        repeat (3) step();
        check("reset_outs", 32'(outs()), 32'd0);
        reset = 1'b1;
        lc0 = load_count;
        repeat (50) step();
        check("idle_no_load", 32'(load_count - lc0), 32'd0);
        check("idle_outs", 32'(outs()), 32'd0);

        // Song 0: two notes then end marker, done pulsed 10 cycles after each load.
        lc0 = load_count;
        for (int i = 0; i < 13; i++) begin
            play = vecs[i].play;
            song = vecs[i].song;
            sif.done_with_note = 1'b0;
            repeat (vecs[i].skip) step();
            sif.done_with_note = vecs[i].done;
            step();
            sif.done_with_note = 1'b0;
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        check("table_loads", 32'(load_count - lc0), 32'd2);

        // play low holds FETCH; issue resumes two cycles after play returns.
        lc0 = load_count;
        repeat (20) step();
        check("gate_no_load", 32'(load_count - lc0), 32'd0);
        check("gate_addr", 32'(outs()), 32'(pack(1'b0, 6'd20, 6'd2, 2'b10, 1'b0, 4'd4)));
        play = 1'b1;
        step();
        check("gate_decode", 32'(sif.load_new_note), 32'd0);
        step();
        check("gate_load", 32'(outs()), 32'(pack(1'b1, 6'd7, 6'd0, 2'b10, 1'b0, 4'd4)));

        // Song change in WAIT_DONE beats a simultaneous done pulse.
        step();
        song = 2'd2;
        sif.done_with_note = 1'b1;
        step();
        sif.done_with_note = 1'b0;
        check("chg_addr", 32'(outs()), 32'(pack(1'b0, 6'd7, 6'd0, 2'b10, 1'b0, 4'd8)));
        step();
        step();
        check("chg_load", 32'(outs()), 32'(pack(1'b1, 6'd63, 6'd63, 2'b01, 1'b0, 4'd8)));

        // Asynchronous reset between edges while waiting for done.
        do_reset();
        song = 2'd3;
        play = 1'b1;
        wait_load(8, w, got);
        check("rst_pre_load", 32'(got), 32'd1);
        step();
        #3 reset = 1'b0;
        #1;
        check("async_reset_outs", 32'(outs()), 32'd0);
        lc0  = load_count;
        play = 1'b0;
        song = 2'd0;
        repeat (3) begin
            sif.done_with_note = 1'b1;
            step();
            sif.done_with_note = 1'b0;
        end
        reset = 1'b1;
        repeat (10) begin
            sif.done_with_note = 1'b1;
            step();
            sif.done_with_note = 1'b0;
        end
        check("rst_done_ignored", 32'(load_count - lc0), 32'd0);
        check("rst_idle_outs", 32'(outs()), 32'd0);

        // Song without end marker: every entry issued, no index wrap.
        do_reset();
        run_song(2'd3, 1'b0);

        for (int it = 0; it < 20; it++) begin
            do_reset();
            for (int k = 0; k < 16; k++)
                rom_mem[k] = {1'($urandom_range(0, 3) == 0), 15'($urandom)};
            run_song(2'($urandom_range(0, 3)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
